spi_master_cfg: RTL and testbench
=================================

Name: spi_master_cfg

Overview:
Parametrised next-generation SPI master. It supports a configurable word width, all four SPI modes (CPOL/CPHA) selected per transfer, MSB- or LSB-first ordering, and a run-time SCLK divider. It drives up to 2**SEL_W slave selects. It sits between a local controller (start/done handshake) and the external SPI bus. Every bus output is registered.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
DIV_W, 8, width of the run-time clock-divider input
SEL_W, 2, width of the slave index; number of slave selects NSS = 2**SEL_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  request a transfer; sampled only while idle
tx_data  in  DATA_W  word to transmit, latched on accepted start
cpol  in  1  SCLK idle level; latched on accepted start, tracked while idle
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accepted start
lsb_first  in  1  1: bit 0 first; 0: bit DATA_W-1 first; latched on accepted start
clk_div  in  DIV_W  SCLK half-period = H = clk_div+1 clk cycles; latched on accepted start
ss_sel  in  SEL_W  slave index; latched on accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of transfer
rx_data  out  DATA_W  received word; updated with done, held otherwise
sclk  out  1  SPI clock
ss_n  out  NSS  active-low selects, one-hot-low during a transfer
mosi  out  1  master out; always driven (never Z)
miso  in  1  master in

Behaviour:
- Async reset: busy=0, done=0, rx_data=0, sclk=0, ss_n=all ones, mosi=0, state=IDLE, latched configuration cleared to 0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: sclk<=cpol every cycle. mosi=0. ss_n=all ones. If start=1 at edge k, latch all configuration and tx_data and enter SETUP. ss_n[ss_sel] goes low after edge k and busy=1.
- SETUP: lasts H cycles with sclk at the latched cpol. If cpha=0, mosi presents the first bit from the first SETUP cycle.
- SHIFT: a half-period counter counts 0..H-1. At each wrap, sclk toggles, producing 2*DATA_W edges in total, with edge counter 0..2*DATA_W-1. Odd-numbered edges (1st, 3rd, ...) are leading edges; even-numbered edges are trailing edges.
- cpha=0:
  - miso is sampled into the shift register on the clk edge that generates each leading SCLK edge.
  - mosi advances to the next bit on each trailing edge, except the last one.
- cpha=1:
  - mosi advances to the next bit on each leading edge. The first leading edge presents bit 0 of the sequence.
  - miso is sampled on each trailing edge.
- Bit order follows the latched lsb_first. Received bits are assembled so that rx_data equals the serial word in the same order convention: a loopback of miso to mosi returns tx_data.
- After the 2*DATA_W-th edge, sclk equals cpol. Enter HOLD.
- HOLD: H cycles, ss_n still asserted, mosi holds the last bit.
- End of HOLD:
  - ss_n=all ones, busy=0, done=1 for exactly one cycle, rx_data<=assembled word, return to IDLE.
  - Total: done is high in the cycle beginning at edge k + H*(2*DATA_W+2).
- start while busy=1 is ignored; no queueing.
- start in the done cycle is accepted, giving back-to-back transfers with ss_n high for exactly one cycle between them.
- Configuration inputs changing mid-transfer have no effect.
- clk_div=0 gives H=1, i.e. SCLK = clk/2. clk_div = all ones gives H = 2**DIV_W. The half-period counter is DIV_W bits and must not overflow.
- ss_sel is always in range (NSS = 2**SEL_W). Exactly one ss_n bit is low during a transfer.
- rst asserted mid-transfer: immediately returns to the reset values above. No done pulse. rx_data=0.

Test Plan:
- Mode 0, MSB-first, DATA_W=8, clk_div=0, tx_data=0xA5, miso looped to mosi -> 8 rising sclk edges; done exactly 18 cycles after the start edge; rx_data=0xA5; busy high for 18 cycles.
- Mode 3, lsb_first=1, clk_div=3, tx_data=0x3C, slave drives 0x96 LSB-first -> sclk idles high; mosi sequence 0,0,1,1,1,1,0,0; done at 72 cycles; rx_data=0x96.
- Mode 1 and mode 2 sweep, clk_div=1, tx_data=0x81 looped back -> each rx_data=0x81; sampling occurs on trailing (mode 1) or leading (mode 2) edges, checked against a bus-level SPI slave model.
- ss_sel=2 (SEL_W=2) -> ss_n=4'b1011 throughout SETUP/SHIFT/HOLD; 4'b1111 in done cycle and IDLE.
- start pulsed while busy, plus tx_data/cpol changes mid-transfer -> ignored, no second transfer. start in the done cycle -> second transfer begins next cycle, ss_n high for exactly 1 cycle.
- rst asserted at edge 5 of SHIFT -> same cycle: ss_n=all ones, sclk=0, mosi=0, busy=0, rx_data=0, no done. A fresh transfer after release completes normally.

Source files
------------

// File: rtl/spi_master_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg_if
// Brief    : Controller handshake and SPI bus signals of spi_master_cfg.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_cfg_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = 2
);
    localparam int C_NSS = 2 ** SEL_W;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [SEL_W-1:0]  ss_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic [C_NSS-1:0]  ss_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, tx_data, cpol, cpha, lsb_first, clk_div, ss_sel, miso,
        output busy, done, rx_data, sclk, ss_n, mosi
    );

    modport slave (
        output start, tx_data, cpol, cpha, lsb_first, clk_div, ss_sel, miso,
        input  busy, done, rx_data, sclk, ss_n, mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg
// Brief    : SPI master, per-transfer CPOL/CPHA, bit order and SCLK divider.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_cfg_if.master bus
);
    localparam int C_NSS    = 2 ** SEL_W;
    localparam int C_EDGE_W = $clog2(2 * DATA_W);
    localparam int C_IDX_W  = C_EDGE_W - 1;
    localparam logic [C_EDGE_W-1:0] C_LAST_EDGE = C_EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [DIV_W-1:0]    cnt_q,     cnt_d;
    logic [C_EDGE_W-1:0] edge_q,    edge_d;
    logic [DATA_W-1:0]   tx_q,      tx_d;
    logic [DATA_W-1:0]   rx_sr_q,   rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                cpol_q,    cpol_d;
    logic                cpha_q,    cpha_d;
    logic                lsb_q,     lsb_d;
    logic [DIV_W-1:0]    div_q,     div_d;
    logic [SEL_W-1:0]    sel_q,     sel_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                sclk_q,    sclk_d;
    logic                mosi_q,    mosi_d;
    logic [C_NSS-1:0]    ss_n_q,    ss_n_d;

    logic               w_half_end;
    logic               w_leading;
    logic [C_IDX_W-1:0] w_pos;

    // Picks the p-th bit of the serial sequence for the given order.
    function automatic logic sel_bit(input logic [DATA_W-1:0] w,
                                     input logic lsb,
                                     input logic [C_IDX_W-1:0] p);
        logic [C_IDX_W-1:0] i;
        i = lsb ? p : (C_IDX_W'(DATA_W - 1) - p);
        return w[i];
    endfunction

    assign w_half_end = (cnt_q == div_q);
    assign w_leading  = ~edge_q[0];
    assign w_pos      = edge_q[C_EDGE_W-1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            div_q     <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            div_q     <= div_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        div_d     = div_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;

        unique case (state_q)
            ST_IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                ss_n_d = '1;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_sr_d = '0;
                    tx_d    = bus.tx_data;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    lsb_d   = bus.lsb_first;
                    div_d   = bus.clk_div;
                    sel_d   = bus.ss_sel;
                    busy_d  = 1'b1;
                    ss_n_d  = ~(C_NSS'(1) << bus.ss_sel);
                    // CPHA=1 launches its first bit on the first leading edge instead
                    mosi_d  = bus.cpha ? 1'b0 : sel_bit(bus.tx_data, bus.lsb_first, '0);
                end
            end

            ST_SETUP: begin
                sclk_d = cpol_q;
                ss_n_d = ~(C_NSS'(1) << sel_q);
                if (w_half_end) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            ST_SHIFT: begin
                ss_n_d = ~(C_NSS'(1) << sel_q);
                if (w_half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + C_EDGE_W'(1);
                    // Sample side is the leading edge for CPHA=0, trailing for CPHA=1
                    if (w_leading ^ cpha_q) begin
                        rx_sr_d = lsb_q ? {bus.miso, rx_sr_q[DATA_W-1:1]}
                                        : {rx_sr_q[DATA_W-2:0], bus.miso};
                    end
                    if (cpha_q && w_leading) begin
                        mosi_d = sel_bit(tx_q, lsb_q, w_pos);
                    end else if (!cpha_q && !w_leading && (edge_q != C_LAST_EDGE)) begin
                        mosi_d = sel_bit(tx_q, lsb_q, w_pos + C_IDX_W'(1));
                    end
                    if (edge_q == C_LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            ST_HOLD: begin
                ss_n_d = ~(C_NSS'(1) << sel_q);
                if (w_half_end) begin
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    ss_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sr_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.sclk    = sclk_q;
    assign bus.ss_n    = ss_n_q;
    assign bus.mosi    = mosi_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cfg
// Brief    : Randomised bench for spi_master_cfg with a cycle-level SPI slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int SEL_W  = 2;
    localparam int NSS    = 1 << SEL_W;

    typedef struct packed {
        logic [DATA_W-1:0] tx;
        logic              cpol;
        logic              cpha;
        logic              lsb;
        logic [DIV_W-1:0]  div;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] sw;
        logic              loopb;
        logic              scr;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic slave_miso;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_master_cfg_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .SEL_W(SEL_W)) bus ();

    spi_master_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.miso = loop_en ? bus.mosi : slave_miso;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t mk(input logic [7:0] tx, input logic cpol, input logic cpha,
                                input logic lsb, input logic [7:0] div, input logic [1:0] sel,
                                input logic [7:0] sw, input logic loopb, input logic scr);
        cfg_t r;
        r.tx = tx; r.cpol = cpol; r.cpha = cpha; r.lsb = lsb; r.div = div;
        r.sel = sel; r.sw = sw; r.loopb = loopb; r.scr = scr;
        return r;
    endfunction

    function automatic cfg_t rnd_cfg(input int max_div);
        cfg_t r;
        r.tx    = DATA_W'($urandom);
        r.cpol  = 1'($urandom);
        r.cpha  = 1'($urandom);
        r.lsb   = 1'($urandom);
        r.div   = DIV_W'($urandom_range(max_div, 0));
        r.sel   = SEL_W'($urandom);
        r.sw    = DATA_W'($urandom);
        r.loopb = 1'($urandom);
        r.scr   = 1'($urandom);
        return r;
    endfunction

    // i-th bit on the wire for word w in the given order
    function automatic logic seq_bit(input logic [DATA_W-1:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[DATA_W-1-i];
    endfunction

    task automatic drive(input cfg_t c, input logic st);
        bus.tx_data   = c.tx;
        bus.cpol      = c.cpol;
        bus.cpha      = c.cpha;
        bus.lsb_first = c.lsb;
        bus.clk_div   = c.div;
        bus.ss_sel    = c.sel;
        bus.start     = st;
    endtask

    // Caller has driven c with start=1; the next posedge accepts it.
    task automatic xfer(input cfg_t c, input logic chain, input cfg_t nx);
        int h, total, t, t_done, edges, p, win_err, edge_err;
        logic prev_sclk;
        logic [DATA_W-1:0] cap, rx_prev, exp_rx;
        h        = int'(c.div) + 1;
        total    = h * (2 * DATA_W + 2);
        exp_rx   = c.loopb ? c.tx : c.sw;
        t_done   = -1;
        edges    = 0;
        win_err  = 0;
        edge_err = 0;
        cap      = '0;
        rx_prev  = '0;
        prev_sclk = 1'b0;
        loop_en  = c.loopb;
        @(posedge clk);
        for (t = 0; t <= total + 3 && t_done < 0; t++) begin
            @(negedge clk);
            if (t == 0) begin
                rx_prev   = bus.rx_data;
                prev_sclk = bus.sclk;
                if (!c.cpha) slave_miso = seq_bit(c.sw, c.lsb, 0);
            end else if (bus.sclk !== prev_sclk) begin
                edges++;
                if (t != h * (edges + 1)) edge_err++;
                p = (edges - 1) / 2;
                if ((edges % 2 == 1) != c.cpha) begin
                    cap[c.lsb ? p : DATA_W-1-p] = bus.mosi;
                end else if (c.cpha) begin
                    slave_miso = seq_bit(c.sw, c.lsb, p);
                end else if (edges < 2 * DATA_W) begin
                    slave_miso = seq_bit(c.sw, c.lsb, edges / 2);
                end
                prev_sclk = bus.sclk;
            end
            if (t < total) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.rx_data !== rx_prev ||
                    bus.ss_n !== ~(4'b0001 << c.sel))
                    win_err++;
                if (t < h && bus.sclk !== c.cpol) edge_err++;
            end else if (bus.done === 1'b1) begin
                t_done = t;
                chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
                chk("done_idle", {bus.busy, bus.ss_n, bus.sclk, bus.mosi},
                    {1'b0, {NSS{1'b1}}, c.cpol, 1'b0});
            end
            if (t_done >= 0) begin
                if (chain) drive(nx, 1'b1);
                else       bus.start = 1'b0;
            end else if (c.scr && t < total) begin
                drive(rnd_cfg(255), 1'($urandom));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = chain && (t_done >= 0);
        chk("done_lat", t_done, total);
        chk("sclk_edges", edges, 2 * DATA_W);
        chk("edge_timing", edge_err, 0);
        chk("busy_ss_win", win_err, 0);
        chk("slave_rx", 32'(cap), 32'(c.tx));
        if (!chain) begin
            @(negedge clk);
            chk("no_restart", {bus.busy, bus.ss_n}, {1'b0, {NSS{1'b1}}});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c, n;
        logic chain;
        logic saw_done;
        rst        = 1'b1;
        loop_en    = 1'b0;
        slave_miso = 1'b0;
        drive(mk(8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h00, 1'b0, 1'b0), 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_outs", {bus.busy, bus.done, bus.sclk, bus.mosi, bus.ss_n}, {4'b0000, {NSS{1'b1}}});
        chk("rst_rx", 32'(bus.rx_data), 32'h0);
        rst = 1'b0;

        c = mk(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h00, 1'b1, 1'b0);
        drive(c, 1'b1); xfer(c, 1'b0, c);
        c = mk(8'h3C, 1'b1, 1'b1, 1'b1, 8'd3, 2'd1, 8'h96, 1'b0, 1'b0);
        drive(c, 1'b1); xfer(c, 1'b0, c);
        c = mk(8'h81, 1'b0, 1'b1, 1'b0, 8'd1, 2'd3, 8'h00, 1'b1, 1'b0);
        drive(c, 1'b1); xfer(c, 1'b0, c);
        c = mk(8'h81, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 8'h00, 1'b1, 1'b0);
        drive(c, 1'b1); xfer(c, 1'b0, c);

        // Slave 2 with inputs scrambled mid-transfer, chained straight into random traffic
        c = mk(8'h5A, 1'b0, 1'b0, 1'b0, 8'd2, 2'd2, 8'hC3, 1'b0, 1'b1);
        n = rnd_cfg(3);
        drive(c, 1'b1); xfer(c, 1'b1, n);
        c = n;
        for (int i = 0; i < 12; i++) begin
            n = (i == 11) ? mk(8'h6E, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd3, 8'h4B, 1'b0, 1'b0)
                          : rnd_cfg(5);
            chain = 1'($urandom);
            xfer(c, chain, n);
            if (!chain) drive(n, 1'b1);
            c = n;
        end
        xfer(c, 1'b0, c);

        c = mk(8'hF0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1, 8'h0F, 1'b0, 1'b0);
        drive(c, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {bus.busy, bus.done, bus.sclk, bus.mosi, bus.ss_n}, {4'b0000, {NSS{1'b1}}});
        chk("rst_mid_rx", 32'(bus.rx_data), 32'h0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        c = mk(8'h69, 1'b0, 1'b1, 1'b1, 8'd2, 2'd3, 8'hD2, 1'b0, 1'b0);
        drive(c, 1'b1); xfer(c, 1'b0, c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
